// File: rtl/approx_mul8_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul8_seq_if
// Description : Operand/result handshake bundle for the approx_mul8_seq
//               multiplier. The master side presents operands and accepts the
//               product. The slave side is the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface approx_mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/approx_mul8_seq.sv
`default_nettype none
// ============================================================================
// Module      : approx_mul8_seq
// Description : Sequential radix-2 shift-and-add 8x8 unsigned multiplier.
//               One multiplier bit is consumed per cycle. The low APPROX_BITS
//               accumulator columns are merged with a carry-free OR. The upper
//               columns use exact addition.
//               Optional macro APPROX_MUL_EARLY_EXIT_EN ends the RUN phase
//               once the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mul8_seq #(
    parameter int APPROX_BITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    approx_mul8_seq_if.slave   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_product;
    logic [2:0]  r_cnt;
    logic [15:0] w_pp;
    logic [15:0] w_acc_sum;
    logic [15:0] w_acc_next;
    logic        w_last;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_busy;

    // Partial product for the current multiplier bit.
    assign w_pp = {8'd0, r_a} << r_cnt;

    // Accumulator update: OR in the low columns, exact add above them.
    // The low field deliberately produces no carry into the high field.
    generate
        if (APPROX_BITS == 0) begin : g_exact
            assign w_acc_sum = r_acc + w_pp;
        end else begin : g_approx
            assign w_acc_sum[APPROX_BITS-1:0] = r_acc[APPROX_BITS-1:0] | w_pp[APPROX_BITS-1:0];
            assign w_acc_sum[15:APPROX_BITS]  = r_acc[15:APPROX_BITS] + w_pp[15:APPROX_BITS];
        end
    endgenerate

    assign w_acc_next = r_b[r_cnt] ? w_acc_sum : r_acc;

`ifdef APPROX_MUL_EARLY_EXIT_EN
    // Finish once no set multiplier bits remain above the current one.
    assign w_last = (r_cnt == 3'd7) || (((r_b >> r_cnt) >> 1) == 8'd0);
`else
    assign w_last = (r_cnt == 3'd7);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Operand capture, shift-and-add accumulation and product latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= 8'd0;
            r_b       <= 8'd0;
            r_acc     <= 16'd0;
            r_cnt     <= 3'd0;
            r_product <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_acc <= 16'd0;
                        r_cnt <= 3'd0;
                    end
                end
                c_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_product <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul8_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_mul8_seq
// Description : Self-checking bench for approx_mul8_seq. Three instances
//               (APPROX_BITS = 0, 4, 8) share one stimulus stream and are
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mul8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    // Clock generation.
    always #5 clk = ~clk;

    approx_mul8_seq_if if0 ();
    approx_mul8_seq_if if4 ();
    approx_mul8_seq_if if8 ();

    assign if0.in_valid = in_valid;
    assign if0.a = a;
    assign if0.b = b;
    assign if0.out_ready = out_ready;
    assign if4.in_valid = in_valid;
    assign if4.a = a;
    assign if4.b = b;
    assign if4.out_ready = out_ready;
    assign if8.in_valid = in_valid;
    assign if8.a = a;
    assign if8.b = b;
    assign if8.out_ready = out_ready;

    approx_mul8_seq #(.APPROX_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    approx_mul8_seq #(.APPROX_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    approx_mul8_seq #(.APPROX_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    int          abits [3] = '{0, 4, 8};
    logic [15:0] p     [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        bz    [3];

    assign p[0] = if0.product;
    assign p[1] = if4.product;
    assign p[2] = if8.product;
    assign ir[0] = if0.in_ready;
    assign ir[1] = if4.in_ready;
    assign ir[2] = if8.in_ready;
    assign ov[0] = if0.out_valid;
    assign ov[1] = if4.out_valid;
    assign ov[2] = if8.out_valid;
    assign bz[0] = if0.busy;
    assign bz[1] = if4.busy;
    assign bz[2] = if8.busy;

    // Reference: for each set bit of y, OR the low field, add the high field
    // modulo its width, no carry between the two fields.
    function automatic logic [15:0] model(input int ab, input logic [7:0] x, input logic [7:0] y);
        int acc = 0;
        int lowmask = (1 << ab) - 1;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                int pp = int'(x) << i;
                int lo = (acc & lowmask) | (pp & lowmask);
                int hi = ((acc >> ab) + (pp >> ab)) % (1 << (16 - ab));
                acc = (hi << ab) | lo;
            end
        end
        return acc[15:0];
    endfunction

    function automatic int exp_lat(input logic [7:0] y);
`ifdef APPROX_MUL_EARLY_EXIT_EN
        for (int i = 7; i >= 0; i--) begin
            if (y[i]) return i + 1;
        end
        return 1;
`else
        return 8;
`endif
    endfunction

    // Offer one operand pair and wait for out_valid; lat=-1 on timeout.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, output int lat);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ov[0]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'd0;
        b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({ir[d], ov[d], bz[d]} !== 3'b100) begin
                bad++;
                $display("FAIL reset_flags dut%0d: got ir/ov/busy=%b%b%b want 100", d, ir[d], ov[d], bz[d]);
            end
            total++;
            if (p[d] !== 16'd0) begin
                bad++;
                $display("FAIL reset_product dut%0d: got %h want 0000", d, p[d]);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] xs [5] = '{8'd13, 8'd255, 8'd0,   8'd15, 8'd16};
        logic [7:0] ys [5] = '{8'd11, 8'd255, 8'd200, 8'd3,  8'd16};
        int lat;
        for (int t = 0; t < 5; t++) begin
            run_op(xs[t], ys[t], lat);
            total++;
            if (lat !== exp_lat(ys[t])) begin
                bad++;
                $display("FAIL dir_latency %0d*%0d: got %0d want %0d", xs[t], ys[t], lat, exp_lat(ys[t]));
            end
            total++;
            if (p[0] !== 16'(xs[t] * ys[t])) begin
                bad++;
                $display("FAIL dir_exact %0d*%0d: got %0d want %0d", xs[t], ys[t], p[0], xs[t] * ys[t]);
            end
            for (int d = 1; d < 3; d++) begin
                total++;
                if (p[d] !== model(abits[d], xs[t], ys[t])) begin
                    bad++;
                    $display("FAIL dir_approx%0d %0d*%0d: got %0d want %0d", abits[d], xs[t], ys[t], p[d], model(abits[d], xs[t], ys[t]));
                end
            end
            total++;
            if ({ir[0], ov[0], bz[0], ov[1], ov[2]} !== 5'b01111) begin
                bad++;
                $display("FAIL dir_done_flags: got ir/ov/busy/ov4/ov8=%b%b%b%b%b want 01111", ir[0], ov[0], bz[0], ov[1], ov[2]);
            end
            release_out();
            total++;
            if ({ir[0], ov[0], bz[0]} !== 3'b100) begin
                bad++;
                $display("FAIL dir_idle_after: got ir/ov/busy=%b%b%b want 100", ir[0], ov[0], bz[0]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0] x;
        logic [7:0] y;
        for (int t = 0; t < 30; t++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run_op(x, y, lat);
            total++;
            if (lat !== exp_lat(y)) begin
                bad++;
                $display("FAIL rnd_latency %0d*%0d: got %0d want %0d", x, y, lat, exp_lat(y));
            end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (p[d] !== model(abits[d], x, y)) begin
                    bad++;
                    $display("FAIL rnd_product%0d %0d*%0d: got %0d want %0d", abits[d], x, y, p[d], model(abits[d], x, y));
                end
                total++;
                if (int'(p[d]) > int'(x) * int'(y)) begin
                    bad++;
                    $display("FAIL rnd_bound%0d %0d*%0d: got %0d want <= %0d", abits[d], x, y, p[d], x * y);
                end
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] x = 8'd201;
        logic [7:0] y = 8'd77;
        run_op(x, y, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({ir[0], ov[0], bz[0]} !== 3'b011) begin
                bad++;
                $display("FAIL bp_flags cyc%0d: got ir/ov/busy=%b%b%b want 011", c, ir[0], ov[0], bz[0]);
            end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (p[d] !== model(abits[d], x, y)) begin
                    bad++;
                    $display("FAIL bp_hold%0d cyc%0d: got %0d want %0d", abits[d], c, p[d], model(abits[d], x, y));
                end
            end
        end
        in_valid = 1'b0;
        release_out();
        total++;
        if ({ir[0], ov[0], bz[0]} !== 3'b100) begin
            bad++;
            $display("FAIL bp_release: got ir/ov/busy=%b%b%b want 100", ir[0], ov[0], bz[0]);
        end
        @(posedge clk);
        #1;
        total++;
        if (bz[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_ignored_input: got busy=%b want 0", bz[0]);
        end
        run_op(8'd6, 8'd7, lat);
        total++;
        if (p[0] !== 16'd42) begin
            bad++;
            $display("FAIL bp_next_op: got %0d want 42", p[0]);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        in_valid = 1'b1;
        a = 8'hAB;
        b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({ir[d], ov[d], bz[d]} !== 3'b100 || p[d] !== 16'd0) begin
                bad++;
                $display("FAIL midrst_state dut%0d: got ir/ov/busy=%b%b%b prod=%0d want 100 prod=0", d, ir[d], ov[d], bz[d], p[d]);
            end
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ov[0] || ov[1] || ov[2]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_pulse: got out_valid seen=%b want 0", seen);
        end
        run_op(8'd3, 8'd5, lat);
        total++;
        if (p[0] !== 16'd15 || lat !== exp_lat(8'd5)) begin
            bad++;
            $display("FAIL midrst_fresh: got prod=%0d lat=%0d want prod=15 lat=%0d", p[0], lat, exp_lat(8'd5));
        end
        release_out();
    endtask

    task automatic test_early_exit();
        int lat;
        logic [7:0] ys [2] = '{8'd2, 8'd0};
        for (int t = 0; t < 2; t++) begin
            run_op(8'd7, ys[t], lat);
            total++;
            if (lat !== exp_lat(ys[t]) || p[0] !== 16'(7 * ys[t])) begin
                bad++;
                $display("FAIL early_exit 7*%0d: got lat=%0d prod=%0d want lat=%0d prod=%0d", ys[t], lat, p[0], exp_lat(ys[t]), 7 * ys[t]);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_early_exit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
